// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   Sequencer between a CPU valid/ready request port and a 256-byte block RAM.
//   Each request becomes one RAM access (byte) or two (16-bit, little-endian,
//   second address wraps mod 256). Every access is a one-cycle address/data
//   setup, then ram_clk held high for HOLD_CYC cycles, then held low for
//   HOLD_CYC cycles. Read data is captured on the last low cycle. A single
//   response strobe follows the final access.
//
// Ports
//   clk_qzt    board quartz clock, all state on its rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present          req_ready  high only when idle
//   req_we     1 = write, 0 = read      req_wide   1 = 16-bit, 0 = byte
//   req_addr   low-byte address         req_wdata  [7:0] -> addr, [15:8] -> addr+1
//   rsp_valid  one-cycle response       rsp_rdata  read data ([15:8] = 0 for byte)
//   busy       high in every state except IDLE
//   ram_clk    RAM strobe               ram_en / ram_we  RAM enable / write enable
//   ram_addr   RAM address              ram_wdata  RAM data in
//   ram_rdata  RAM data out
module mem_bus_ctrl #(
  parameter int HOLD_CYC = 4
) (
  input  logic        clk_qzt,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_wide,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        ram_clk,
  output logic        ram_en,
  output logic        ram_we,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Counter runs HOLD_CYC-1 down to 0, so each phase spans exactly HOLD_CYC cycles.
  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYC - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        idx;
  logic        lat_wide;
  logic [7:0]  lat_addr;
  logic [7:0]  lat_whi;

  assign req_ready = (state == IDLE);

  // Outputs are registered and updated on the transition into the state
  // they belong to, so they are glitch-free toward the edge-detecting RAM.
  always_ff @(posedge clk_qzt or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      idx       <= 1'b0;
      lat_wide  <= 1'b0;
      lat_addr  <= 8'd0;
      lat_whi   <= 8'd0;
      ram_clk   <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= 8'd0;
      ram_wdata <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_wide  <= req_wide;
            lat_addr  <= req_addr;
            lat_whi   <= req_wdata[15:8];
            idx       <= 1'b0;
            rsp_rdata <= 16'd0;
            ram_addr  <= req_addr;
            ram_wdata <= req_wdata[7:0];
            ram_we    <= req_we;
            ram_en    <= 1'b1;
            ram_clk   <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end

        SETUP: begin
          ram_clk <= 1'b1;
          cnt     <= HOLD_M1;
          state   <= HIGH;
        end

        HIGH: begin
          if (cnt == 8'd0) begin
            ram_clk <= 1'b0;
            cnt     <= HOLD_M1;
            state   <= LOW;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        LOW: begin
          if (cnt == 8'd0) begin
            if (idx) rsp_rdata[15:8] <= ram_rdata;
            else     rsp_rdata[7:0]  <= ram_rdata;
            if (lat_wide && !idx) begin
              // Second byte of a wide access; 8-bit add wraps 0xFF -> 0x00.
              idx       <= 1'b1;
              ram_addr  <= lat_addr + 8'd1;
              ram_wdata <= lat_whi;
              state     <= SETUP;
            end else begin
              ram_en    <= 1'b0;
              ram_we    <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= DONE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        DONE: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          ram_clk   <= 1'b0;
          ram_en    <= 1'b0;
          ram_we    <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl
//   Self-checking bench for mem_bus_ctrl with HOLD_CYC = 2. Contains a
//   behavioural read-first RAM that commits an access only after seeing
//   ram_clk high on two consecutive clk_qzt edges, a response scoreboard,
//   a ram_clk pulse monitor, a table of request vectors and hand-written
//   back-to-back and reset-abort sequences.
module tb_mem_bus_ctrl;

  localparam int HOLD = 2;

  logic        clk_qzt;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_wide;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        ram_clk;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  int          n_cmp;
  int          n_fail;
  int          rise_cnt;
  int          rsp_cnt;
  bit          pulse_chk;

  typedef struct {
    logic        we;
    logic        wide;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [11];

  mem_bus_ctrl #(.HOLD_CYC(HOLD)) dut (
    .clk_qzt   (clk_qzt),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_wide  (req_wide),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .ram_clk   (ram_clk),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial begin
    clk_qzt = 1'b0;
    forever #5 clk_qzt = ~clk_qzt;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read-first RAM; the strobe must be seen high on two consecutive edges.
  initial begin
    int q;
    q = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h20] = 8'h11;
    mem[8'hFF] = 8'h77;
    mem[8'h00] = 8'h66;
    mem[8'h40] = 8'h9A;
    mem[8'h41] = 8'hBC;
    mem[8'h50] = 8'h01;
    mem[8'h51] = 8'h02;
    ram_rdata = 8'h00;
    forever begin
      @(posedge clk_qzt);
      if (ram_clk && ram_en) begin
        if (q == 1) begin
          ram_rdata <= mem[ram_addr];
          if (ram_we) mem[ram_addr] <= ram_wdata;
        end
        q++;
      end else begin
        q = 0;
      end
    end
  end

  // Response scoreboard.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk_qzt);
      if (rst_n && rsp_valid) begin
        rsp_cnt++;
        chk("ready_in_done", 32'(req_ready), 32'd0);
        chk("ram_clk_in_done", 32'(ram_clk), 32'd0);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_rdata), 32'hDEAD_0000);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e));
        end
      end
    end
  end

  // ram_clk pulse monitor: one rise per byte, each high phase HOLD cycles.
  initial begin
    int hi;
    hi = 0;
    forever begin
      @(negedge clk_qzt);
      if (!rst_n || !pulse_chk) begin
        hi = 0;
      end else if (ram_clk) begin
        if (hi == 0) begin
          rise_cnt++;
          chk("ram_en_at_rise", 32'(ram_en), 32'd1);
        end
        hi++;
      end else if (hi != 0) begin
        chk("ram_clk_width", 32'(hi), 32'(HOLD));
        hi = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic we, input logic wide, input logic [7:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp);
    int n;
    int r0;
    n = 0;
    @(negedge clk_qzt);
    while (!req_ready && n < 50) begin
      @(negedge clk_qzt);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_wide  = wide;
    req_addr  = addr;
    req_wdata = wdata;
    exp_q.push_back(exp);
    r0 = rise_cnt;
    @(negedge clk_qzt);
    // Scramble the request after accept; it must have no effect.
    req_valid = 1'b0;
    req_we    = ~we;
    req_wide  = ~wide;
    req_addr  = addr ^ 8'h5A;
    req_wdata = ~wdata;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(req_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk_qzt);
      n++;
    end
    chk("latency", 32'(n), wide ? 32'(2 + 4 * HOLD) : 32'(1 + 2 * HOLD));
    chk("ram_clk_rises", 32'(rise_cnt - r0), wide ? 32'd2 : 32'd1);
  endtask

  initial begin
    int acc;
    int brise;
    int r;
    int n;
    logic pb;

    vecs[0]  = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5};
    vecs[1]  = '{1'b1, 1'b0, 8'h20, 16'h003C, 16'h0011};
    vecs[2]  = '{1'b0, 1'b0, 8'h20, 16'h0000, 16'h003C};
    vecs[3]  = '{1'b1, 1'b1, 8'hFF, 16'hBEEF, 16'h6677};
    vecs[4]  = '{1'b0, 1'b1, 8'hFF, 16'h0000, 16'hBEEF};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h00BE};
    vecs[6]  = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'h00EF};
    vecs[7]  = '{1'b1, 1'b1, 8'h40, 16'h1234, 16'hBC9A};
    vecs[8]  = '{1'b0, 1'b1, 8'h40, 16'h0000, 16'h1234};
    vecs[9]  = '{1'b1, 1'b0, 8'h30, 16'hFF55, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 8'h30, 16'h0000, 16'h0055};

    n_cmp = 0; n_fail = 0; rise_cnt = 0; rsp_cnt = 0; pulse_chk = 1'b1;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_wide = 1'b0;
    req_addr = 8'h00; req_wdata = 16'h0000;

    repeat (3) @(negedge clk_qzt);
    chk("rst_ram_clk", 32'(ram_clk), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_qzt);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ram_clk", 32'(ram_clk), 32'd0);
    chk("idle_ram_en", 32'(ram_en), 32'd0);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("idle_ram_addr", 32'(ram_addr), 32'd0);

    for (int i = 0; i < 11; i++)
      do_req(vecs[i].we, vecs[i].wide, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    chk("mem_ff_after_wide", 32'(mem[8'hFF]), 32'hEF);
    chk("mem_00_after_wide", 32'(mem[8'h00]), 32'hBE);
    chk("mem_31_untouched", 32'(mem[8'h31]), 32'h00);

    // Back-to-back byte reads with req_valid held high.
    @(negedge clk_qzt);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk_qzt);
      n++;
    end
    acc = 0; brise = 0; r = rsp_cnt; pb = busy;
    for (int k = 0; k < 3; k++) exp_q.push_back(16'h00A5);
    req_valid = 1'b1; req_we = 1'b0; req_wide = 1'b0; req_addr = 8'h10; req_wdata = 16'h0000;
    for (int c = 0; c < 80; c++) begin
      if (acc == 3) req_valid = 1'b0;
      else if (req_ready) acc++;
      @(negedge clk_qzt);
      if (busy && !pb) brise++;
      pb = busy;
      if (rsp_cnt - r == 3) break;
    end
    req_valid = 1'b0;
    repeat (10) begin
      @(negedge clk_qzt);
      if (busy && !pb) brise++;
      pb = busy;
    end
    chk("b2b_accepts", 32'(brise), 32'd3);
    chk("b2b_responses", 32'(rsp_cnt - r), 32'd3);

    // Reset during the high phase of the second byte of a wide write.
    pulse_chk = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_wide = 1'b1; req_addr = 8'h50; req_wdata = 16'hD00D;
    @(negedge clk_qzt);
    req_valid = 1'b0;
    n = 0;
    while (!(ram_clk && ram_addr == 8'h51) && n < 40) begin
      @(negedge clk_qzt);
      n++;
    end
    chk("abort_reached_byte1", 32'(ram_clk && ram_addr == 8'h51), 32'd1);
    r = rsp_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ram_clk_drop", 32'(ram_clk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ram_en", 32'(ram_en), 32'd0);
    repeat (3) @(negedge clk_qzt);
    rst_n = 1'b1;
    repeat (15) @(negedge clk_qzt);
    chk("abort_no_rsp", 32'(rsp_cnt - r), 32'd0);
    chk("abort_mem_50", 32'(mem[8'h50]), 32'h0D);
    chk("abort_mem_51", 32'(mem[8'h51]), 32'h02);
    pulse_chk = 1'b1;
    do_req(1'b0, 1'b0, 8'h50, 16'h0000, 16'h000D);
    do_req(1'b0, 1'b0, 8'h51, 16'h0000, 16'h0002);

    repeat (3) @(negedge clk_qzt);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
